// File: rtl/dpcm_if.sv
// Valid/ready bundle between a DPCM difference source, the decoder and the downstream word consumer.
// The slave modport is the decoder's view; master is the view of the logic driving it.
interface dpcm_if #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_mag;
    logic             in_sign;
    logic             in_first;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             wrap_err;
    logic [LVL_W-1:0] level;

    modport master (
        output in_valid, in_mag, in_sign, in_first, out_ready,
        input  in_ready, out_valid, out_data, wrap_err, level
    );

    modport slave (
        input  in_valid, in_mag, in_sign, in_first, out_ready,
        output in_ready, out_valid, out_data, wrap_err, level
    );
endinterface

// File: rtl/dpcm_decoder.sv
// Rebuilds absolute words from sign/magnitude DPCM differences by running accumulation,
// with a small output FIFO so downstream stalls do not stall the link immediately.
module dpcm_decoder #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    dpcm_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_last;
    logic             r_wrap;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic             w_full;
    logic             w_empty;
    logic             w_accept;
    logic             w_pop;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_new_acc;
    logic             w_wrap;

    // in_ready depends only on the registered level, so a same-cycle pop cannot open the input.
    assign w_full   = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty  = (r_level == '0);
    assign w_accept = bus.in_valid && !w_full;
    assign w_pop    = !w_empty && bus.out_ready;

    // The extra top bit of the sum/difference is the carry-out or borrow.
    assign w_sum  = {1'b0, r_acc} + {1'b0, bus.in_mag};
    assign w_diff = {1'b0, r_acc} - {1'b0, bus.in_mag};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_new_acc = bus.in_mag;
        w_wrap    = 1'b0;
        if (r_state == ST_RUN && !bus.in_first) begin
            if (bus.in_sign) begin
                w_new_acc = w_diff[WIDTH-1:0];
                w_wrap    = w_diff[WIDTH];
            end else begin
                w_new_acc = w_sum[WIDTH-1:0];
                w_wrap    = w_sum[WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_last   <= '0;
            r_wrap   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_accept) begin
                r_acc    <= w_new_acc;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                case (r_state)
                    ST_IDLE: begin
                        r_wrap  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (bus.in_first) begin
                            r_wrap <= 1'b0;
                        end else if (w_wrap) begin
                            r_wrap <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_last   <= r_mem[r_rd_ptr];
            end

            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is not reset; the level counter alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_new_acc;
        end
    end

    // With the FIFO empty the last popped word stays on out_data.
    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? r_last : r_mem[r_rd_ptr];
    assign bus.wrap_err  = r_wrap;
    assign bus.level     = r_level;

endmodule

// File: tb/tb_dpcm_decoder.sv
// Scoreboard bench for dpcm_decoder: a reference accumulator predicts each word at accept time,
// a negedge monitor compares every popped word, and scenario tasks check handshake and flags.
module tb_dpcm_decoder;
    localparam int WIDTH      = 32;
    localparam int FIFO_DEPTH = 2;

    logic clk;
    logic rst;

    dpcm_if #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    dpcm_decoder #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      n_cmp = 0;
    int unsigned      n_mis = 0;
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] last_exp = '0;
    logic [WIDTH-1:0] mon_exp;

    logic [WIDTH-1:0] m_acc  = '0;
    bit               m_run  = 1'b0;
    bit               m_wrap = 1'b0;

    // Reference accumulator, stepped once per accepted sample.
    task automatic model_accept(input logic first, input logic sign, input logic [WIDTH-1:0] mag);
        logic [WIDTH:0] t;
        if (!m_run || first) begin
            m_acc  = mag;
            m_wrap = 1'b0;
            m_run  = 1'b1;
        end else if (!sign) begin
            t = {1'b0, m_acc} + {1'b0, mag};
            if (t[WIDTH]) m_wrap = 1'b1;
            m_acc = t[WIDTH-1:0];
        end else begin
            if (mag > m_acc) m_wrap = 1'b1;
            m_acc = m_acc - mag;
        end
        q.push_back(m_acc);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_mis++;
                $display("FAIL out_unexpected: got %h, required no output", bus.out_data);
            end else begin
                mon_exp = q.pop_front();
                last_exp = mon_exp;
                if (bus.out_data !== mon_exp) begin
                    n_mis++;
                    $display("FAIL out_data: got %h, required %h", bus.out_data, mon_exp);
                end
            end
        end
    end

    // Entered and left at posedge+1; in_valid is low on return.
    task automatic send(input logic first, input logic sign, input logic [WIDTH-1:0] mag,
                        input string tag);
        int waited = 0;
        bit done   = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_first = first;
        bus.in_sign  = sign;
        bus.in_mag   = mag;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                model_accept(first, sign, mag);
                done = 1'b1;
            end else begin
                bus.out_ready = 1'b1;
                waited++;
                if (waited > 50) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL %s accept_timeout: got in_ready=%b, required 1", tag, bus.in_ready);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        bus.out_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_mis++;
            $display("FAIL %s drain_timeout: got %0d pending, required 0", tag, q.size());
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL %s empty_valid: got %b, required 0", tag, bus.out_valid);
        end
        n_cmp++;
        if (bus.out_data !== last_exp) begin
            n_mis++;
            $display("FAIL %s empty_hold: got %h, required %h", tag, bus.out_data, last_exp);
        end
    endtask

    task automatic check_flag(input string tag, input logic got, input logic req);
        n_cmp++;
        if (got !== req) begin
            n_mis++;
            $display("FAIL %s: got %b, required %b", tag, got, req);
        end
    endtask

    task automatic check_level(input string tag, input logic [1:0] req);
        n_cmp++;
        if (bus.level !== req) begin
            n_mis++;
            $display("FAIL %s level: got %0d, required %0d", tag, bus.level, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_mag    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_flag("reset in_ready", bus.in_ready, 1'b1);
        check_flag("reset out_valid", bus.out_valid, 1'b0);
        check_flag("reset wrap_err", bus.wrap_err, 1'b0);
        check_level("reset", 2'd0);
        n_cmp++;
        if (bus.out_data !== '0) begin
            n_mis++;
            $display("FAIL reset out_data: got %h, required 0", bus.out_data);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        send(1'b1, 1'b0, 32'd5, "basic0");
        check_flag("basic0 wrap_err", bus.wrap_err, 1'b0);
        send(1'b0, 1'b0, 32'd3, "basic1");
        check_flag("basic1 wrap_err", bus.wrap_err, 1'b0);
        send(1'b0, 1'b1, 32'd10, "basic2");
        check_flag("basic2 wrap_err", bus.wrap_err, 1'b1);
        drain("basic");
    endtask

    task automatic test_absolute();
        send(1'b1, 1'b0, 32'd100, "abs0");
        check_flag("abs0 wrap_err", bus.wrap_err, 1'b0);
        send(1'b0, 1'b0, 32'd0, "abs1");
        check_flag("abs1 wrap_err", bus.wrap_err, 1'b0);
        drain("absolute");
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        send(1'b0, 1'b0, 32'd1, "bp0");
        send(1'b0, 1'b0, 32'd2, "bp1");
        check_level("bp full", 2'd2);
        check_flag("bp full in_ready", bus.in_ready, 1'b0);
        check_flag("bp full out_valid", bus.out_valid, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_first = 1'b0;
        bus.in_sign  = 1'b0;
        bus.in_mag   = 32'd4;
        repeat (3) begin
            @(negedge clk);
            check_flag("bp stall in_ready", bus.in_ready, 1'b0);
            n_cmp++;
            if (bus.out_data !== q[0]) begin
                n_mis++;
                $display("FAIL bp stall out_data: got %h, required %h", bus.out_data, q[0]);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_flag("bp pop_only in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        check_level("bp after pop", 2'd1);
        check_flag("bp after pop in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        if (bus.in_ready === 1'b1) model_accept(1'b0, 1'b0, 32'd4);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_level("bp push_pop", 2'd1);
        drain("back_to_back");
        check_flag("bp end in_ready", bus.in_ready, 1'b1);
        check_level("bp end", 2'd0);
    endtask

    task automatic test_wrap();
        send(1'b1, 1'b0, 32'hFFFF_FFFF, "wrap0");
        check_flag("wrap0 wrap_err", bus.wrap_err, 1'b0);
        send(1'b0, 1'b0, 32'd1, "wrap1");
        check_flag("wrap1 wrap_err", bus.wrap_err, 1'b1);
        send(1'b0, 1'b1, 32'd1, "wrap2");
        check_flag("wrap2 wrap_err", bus.wrap_err, 1'b1);
        drain("wrap");
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        send(1'b0, 1'b0, 32'd5, "mid0");
        send(1'b0, 1'b0, 32'd6, "mid1");
        check_level("mid full", 2'd2);
        rst = 1'b1;
        q.delete();
        m_run  = 1'b0;
        m_acc  = '0;
        m_wrap = 1'b0;
        last_exp = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_flag("mid rst out_valid", bus.out_valid, 1'b0);
        check_flag("mid rst in_ready", bus.in_ready, 1'b1);
        check_flag("mid rst wrap_err", bus.wrap_err, 1'b0);
        check_level("mid rst", 2'd0);
        n_cmp++;
        if (bus.out_data !== '0) begin
            n_mis++;
            $display("FAIL mid rst out_data: got %h, required 0", bus.out_data);
        end
        bus.out_ready = 1'b1;
        send(1'b0, 1'b1, 32'd7, "mid2");
        drain("reset_midstream");
    endtask

    task automatic test_random_stream();
        logic [WIDTH-1:0] mag;
        logic             first;
        logic             sign;
        for (int i = 0; i < 60; i++) begin
            mag   = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 1000));
            first = ($urandom_range(0, 15) == 0);
            sign  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            send(first, sign, mag, "rand");
            check_flag("rand wrap_err", bus.wrap_err, m_wrap);
        end
        drain("random");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_absolute();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
